instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage sitting directly upstream of the immediate generator and decoder. It owns the program counter, issues one instruction-memory read at a time over a valid/ready request channel, and captures the returned word. It presents that word with its PC to decode under a valid/ready handshake, and accepts PC redirects from execute for branches and jumps.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  read request valid.
- imem_req_addr  out  32  word-aligned read address (= pc).
- imem_req_ready  in  1  memory accepts request when high with imem_req_valid.
- imem_rsp_valid  in  1  read data valid; at most one per accepted request.
- imem_rsp_data  in  32  instruction word.
- instr_valid  out  1  instr/instr_pc hold a live instruction.
- instr  out  32  fetched instruction (drives decode/immediate generation).
- instr_pc  out  32  address of instr.
- instr_ready  in  1  downstream consumes instr when high with instr_valid.
- redirect_valid  in  1  load redirect_pc as next fetch address.
- redirect_pc  in  32  branch/jump target.
- fetch_misalign  out  1  one-cycle pulse: last redirect had redirect_pc[1:0] != 0.
- fetch_count  out  32  number of instructions consumed by downstream.

## Operation
- Registers: pc, instr, instr_pc, state, kill flag, fetch_count, fetch_misalign.
- States: IDLE, REQ, WAIT, HOLD.
  - IDLE: entered on reset; unconditional transition to REQ.
  - REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready, go to WAIT.
  - WAIT: sample imem_rsp_valid.
    - On response with kill=0: instr<=imem_rsp_data, instr_pc<=pc, pc<=pc+4, go to HOLD.
    - On response with kill=1: discard data, clear kill, go to REQ.
  - HOLD: instr_valid=1. On instr_ready: fetch_count+=1, go to REQ.
- imem_req_valid and instr_valid are decoded from state only; no input-to-output combinational paths.
- Redirect (redirect_valid=1) has priority over all other events in every state except IDLE. It sets pc<={redirect_pc[31:2],2'b00}, and sets fetch_misalign=1 next cycle if redirect_pc[1:0]!=0.
  - REQ, not accepted this cycle: stay in REQ; the address changes next cycle.
  - REQ, accepted the same cycle: go to WAIT with kill=1.
  - WAIT: set kill=1; the pending response is discarded; remain in WAIT.
  - HOLD: drop the instruction and go to REQ. If instr_ready is also high that cycle, count the instruction as consumed.
- Redirect in IDLE is ignored.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC goes to 32'h0000_0000). fetch_count wraps likewise.
- Reset mid-operation: all state is abandoned immediately, and a response for an abandoned request arriving after reset is ignored because the block is in IDLE/REQ. The memory must not return data for requests accepted before reset.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, kill=0, fetch_count=0, fetch_misalign=0.
- Outputs during reset: imem_req_valid=0, instr_valid=0.
- With zero-wait memory (ready always high, response one cycle after acceptance):
  - cycle 1 after reset release: REQ.
  - cycle 2: WAIT, response sampled.
  - cycle 3: HOLD, instr_valid=1.
- Steady-state throughput: one instruction per 3 cycles if instr_ready is always high.
- imem_rsp_valid in any state other than WAIT is ignored.
- Redirect to new request: imem_req_addr shows the target the cycle after redirect_valid.
- fetch_count updates the cycle after the consuming handshake.

## Test plan
- Reset release, RESET_PC=0, memory returns 32'h00500093 at 0, 32'h00A00113 at 4, instr_ready=1: instr/instr_pc show 00500093/0 then 00A00113/4; fetch_count=2.
- instr_ready held low 5 cycles in HOLD: instr_valid, instr and instr_pc stable, no new request, fetch_count unchanged.
- redirect_pc=32'h100 asserted in WAIT: the returned word is discarded, next imem_req_addr=32'h100, and no instr_valid for the stale word.
- redirect_pc=32'h202 in HOLD together with instr_ready: fetch_misalign pulses once, next address 32'h200, fetch_count increments by 1.
- Memory with imem_req_ready low 3 cycles and response latency 4: single outstanding request, correct instr_pc, no duplicate requests.
- pc=32'hFFFF_FFFC fetch: next imem_req_addr=32'h0.
- Reset asserted in WAIT: outputs return to reset values the next cycle and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch stage bundle: imem request/response, decode handshake, redirect, status
interface instr_fetch_if;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_misalign;
   logic [31:0] fetch_count;

   modport master (
      output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
             fetch_misalign, fetch_count,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
             redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
             fetch_misalign, fetch_count,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
             redirect_valid, redirect_pc
   );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: owns the PC, one outstanding imem read, decode handshake
// Redirects from execute override everything except IDLE; a killed read is drained before refetching.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          reset,
   instr_fetch_if.master bus
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] instr_q;
   logic [31:0] instr_pc_q;
   logic [31:0] fetch_count_q;
   logic        kill;
   logic        fetch_misalign_q;
   logic        redirect;
   logic [31:0] redirect_target;

   assign redirect        = bus.redirect_valid && (state != IDLE);
   assign redirect_target = {bus.redirect_pc[31:2], 2'b00};

   assign bus.imem_req_valid = (state == REQ);
   assign bus.imem_req_addr  = pc;
   assign bus.instr_valid    = (state == HOLD);
   assign bus.instr          = instr_q;
   assign bus.instr_pc       = instr_pc_q;
   assign bus.fetch_misalign = fetch_misalign_q;
   assign bus.fetch_count    = fetch_count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         pc               <= RESET_PC;
         instr_q          <= 32'h0;
         instr_pc_q       <= 32'h0;
         kill             <= 1'b0;
         fetch_count_q    <= 32'h0;
         fetch_misalign_q <= 1'b0;
      end else begin
         fetch_misalign_q <= 1'b0;
         if (redirect) begin
            pc               <= redirect_target;
            fetch_misalign_q <= |bus.redirect_pc[1:0];
         end
         case (state)
            IDLE: state <= REQ;
            REQ: begin
               if (bus.imem_req_ready) begin
                  state <= WAIT;
                  kill  <= redirect;
               end
            end
            WAIT: begin
               if (redirect) begin
                  // A response landing with the redirect is the one being killed; nothing more will come.
                  if (bus.imem_rsp_valid) begin
                     kill  <= 1'b0;
                     state <= REQ;
                  end else begin
                     kill <= 1'b1;
                  end
               end else if (bus.imem_rsp_valid) begin
                  if (kill) begin
                     kill  <= 1'b0;
                     state <= REQ;
                  end else begin
                     instr_q    <= bus.imem_rsp_data;
                     instr_pc_q <= pc;
                     pc         <= pc + 32'd4;
                     state      <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (bus.instr_ready) begin
                  fetch_count_q <= fetch_count_q + 32'd1;
               end
               if (bus.instr_ready || redirect) begin
                  state <= REQ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
